// File: rtl/gpio_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_seq_pkg
// Description : Shared constants for the GPIO pattern sequencer: FSM state
//               encodings, config register offsets and bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_seq_pkg;

  // Sequencer FSM state encoding
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_ISSUE = 2'd1;
  localparam seq_state_t ST_WAIT  = 2'd2;

  // Config register offsets (decoded from addr[3:0])
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_PERIOD = 4'h4;
  localparam logic [3:0] REG_DATA   = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'hC;

  // CTRL bit positions
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;
  localparam int unsigned CTRL_CLEAR = 2;
  localparam int unsigned CTRL_LOOP  = 8;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_PUSH_ERR = 1;
  localparam int unsigned STAT_BUS_ERR  = 2;
  localparam int unsigned STAT_N_LSB    = 8;
  localparam int unsigned STAT_IDX_LSB  = 16;

endpackage
`default_nettype wire

// File: rtl/scarv_ccx_memif.sv
`default_nettype none
// ============================================================================
// Module      : scarv_ccx_memif
// Description : CCX memory bus interface with requester/responder modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface scarv_ccx_memif;
  logic        req;
  logic        gnt;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        error;

  modport REQ (output req, wen, strb, addr, wdata, input gnt, error, rdata);
  modport RSP (input req, wen, strb, addr, wdata, output gnt, error, rdata);
endinterface
`default_nettype wire

// File: rtl/gpio_seq_buf.sv
`default_nettype none
// ============================================================================
// Module      : gpio_seq_buf
// Description : DEPTH x W pattern register file. Appends at write index N,
//               reads combinationally at an external index.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_seq_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             clear_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             do_push;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign count_o = count_q;
  assign rdata_o = mem_q[ridx_i];

  // Pattern storage; contents are not reset
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[count_q[IDX_W-1:0]] <= wdata_i;
    end
  end

  // Fill count: clear empties the buffer, push appends while not full
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpio_seq.sv
`default_nettype none
// ============================================================================
// Module      : gpio_seq
// Description : GPIO pattern sequencer. Config registers on a CCX responder
//               port; replays buffered pattern words as CCX writes to the GPIO
//               OUTPUTS register, one per step, one-shot or looping.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int          DEPTH           = 16,
  parameter int          PERIOD_W        = 16,
  parameter logic [31:0] GPIO_OUT_ADDR   = 32'h0000_0004,
  parameter int          PERIPH_GPIO_NUM = 16
) (
  input  logic               g_clk,
  input  logic               g_reset,
  scarv_ccx_memif.RSP        cfg_if,
  scarv_ccx_memif.REQ        gpio_if,
  output logic               busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  seq_state_t                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [PERIOD_W-1:0]        cnt_q, cnt_d;
  logic [PERIOD_W-1:0]        period_q;
  logic                       loop_q;
  logic                       stop_pend_q, stop_pend_d;
  logic                       push_err_q, bus_err_q;
  logic                       busy_q;
  logic                       req_q;
  logic [31:0]                wdata_q;

  logic [3:0]                 off;
  logic                       cfg_wr, ctrl_wr, period_wr, data_wr, status_wr;
  logic                       start_req, stop_req, clear_req;
  logic                       is_idle, start_go, buf_push, buf_clear, buf_full;
  logic                       last, load_wdata;
  logic [CNT_W-1:0]           count;
  logic [PERIPH_GPIO_NUM-1:0] rd_word;
  logic [31:0]                rdata;
  logic [31:0]                status;

  // Config write decode
  assign off       = cfg_if.addr[3:0];
  assign cfg_wr    = cfg_if.req && cfg_if.wen;
  assign ctrl_wr   = cfg_wr && (off == REG_CTRL);
  assign period_wr = cfg_wr && (off == REG_PERIOD);
  assign data_wr   = cfg_wr && (off == REG_DATA);
  assign status_wr = cfg_wr && (off == REG_STATUS);
  assign start_req = ctrl_wr && cfg_if.wdata[CTRL_START];
  assign stop_req  = ctrl_wr && cfg_if.wdata[CTRL_STOP];
  assign clear_req = ctrl_wr && cfg_if.wdata[CTRL_CLEAR];

  assign is_idle   = (state_q == ST_IDLE);
  // STOP beats START; a CLEAR in the same write also suppresses START
  assign start_go  = start_req && !stop_req && !clear_req && is_idle && (count != '0);
  assign buf_push  = data_wr && is_idle;
  assign buf_clear = clear_req && is_idle;
  assign last      = ({1'b0, idx_q} == (count - 1'b1));

  gpio_seq_buf #(
    .DEPTH (DEPTH),
    .W     (PERIPH_GPIO_NUM),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk_i   (g_clk),
    .rst_i   (g_reset),
    .push_i  (buf_push),
    .clear_i (buf_clear),
    .wdata_i (cfg_if.wdata[PERIPH_GPIO_NUM-1:0]),
    .ridx_i  (idx_d),
    .rdata_o (rd_word),
    .count_o (count),
    .full_o  (buf_full)
  );

  // Step FSM: next state, next index and period counter
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (buf_clear) idx_d = '0;
        if (start_go) begin
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (stop_req) stop_pend_d = 1'b1;
        if (gpio_if.gnt) begin
          cnt_d = period_q;
          if (stop_pend_q || stop_req || (last && !loop_q)) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = last ? '0 : idx_q + 1'b1;
            state_d = (period_q == '0) ? ST_ISSUE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (stop_req) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q <= PERIOD_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // New write data is captured on entry to ISSUE and held until granted
  assign load_wdata = (state_d == ST_ISSUE) && !((state_q == ST_ISSUE) && !gpio_if.gnt);

  // FSM and GPIO request registers
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      req_q       <= (state_d == ST_ISSUE);
      busy_q      <= (state_d != ST_IDLE);
      if (load_wdata) wdata_q <= 32'(rd_word);
    end
  end

  // Config registers and sticky error flags (set has priority over clear)
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      loop_q     <= 1'b0;
      period_q   <= '0;
      push_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (ctrl_wr)   loop_q   <= cfg_if.wdata[CTRL_LOOP];
      if (period_wr) period_q <= cfg_if.wdata[PERIOD_W-1:0];
      if (data_wr && (!is_idle || buf_full))        push_err_q <= 1'b1;
      else if (status_wr && cfg_if.wdata[STAT_PUSH_ERR]) push_err_q <= 1'b0;
      if ((state_q == ST_ISSUE) && gpio_if.gnt && gpio_if.error) bus_err_q <= 1'b1;
      else if (status_wr && cfg_if.wdata[STAT_BUS_ERR])        bus_err_q <= 1'b0;
    end
  end

  // Combinational register read mux
  always_comb begin
    status                             = '0;
    status[STAT_BUSY]                  = busy_q;
    status[STAT_PUSH_ERR]              = push_err_q;
    status[STAT_BUS_ERR]               = bus_err_q;
    status[STAT_N_LSB +: CNT_W]        = count;
    status[STAT_IDX_LSB +: IDX_W]      = idx_q;
    rdata = '0;
    if (cfg_if.req) begin
      case (off)
        REG_CTRL:   rdata[CTRL_LOOP] = loop_q;
        REG_PERIOD: rdata = 32'(period_q);
        REG_STATUS: rdata = status;
        default:    rdata = '0;
      endcase
    end
  end

  assign cfg_if.rdata  = rdata;
  assign cfg_if.gnt    = 1'b1;
  assign cfg_if.error  = 1'b0;

  assign gpio_if.req   = req_q;
  assign gpio_if.wen   = 1'b1;
  assign gpio_if.strb  = 4'hF;
  assign gpio_if.addr  = GPIO_OUT_ADDR;
  assign gpio_if.wdata = wdata_q;

  assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_seq
// Description : Self-checking bench for gpio_seq: register table plus
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_seq;

  logic g_clk = 1'b0;
  logic g_reset = 1'b1;
  logic busy;

  scarv_ccx_memif cfg_if ();
  scarv_ccx_memif gpio_if ();

  gpio_seq #(
    .DEPTH           (16),
    .PERIOD_W        (16),
    .GPIO_OUT_ADDR   (32'h0000_0004),
    .PERIPH_GPIO_NUM (16)
  ) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .cfg_if  (cfg_if),
    .gpio_if (gpio_if),
    .busy    (busy)
  );

  always #5 g_clk = ~g_clk;

  localparam logic [31:0] A_CTRL = 32'h0, A_PER = 32'h4, A_DATA = 32'h8, A_STAT = 32'hC;

  int passed = 0;
  int total  = 0;

  // GPIO-side monitor: granted writes, req rising-edge cycles, attribute errors
  int          cyc = 0;
  logic        prev_req = 1'b0;
  int          attr_bad = 0;
  logic [31:0] wr_q[$];
  int          edge_q[$];

  always @(posedge g_clk) cyc <= cyc + 1;

  always @(negedge g_clk) begin
    if (gpio_if.req && !prev_req) edge_q.push_back(cyc);
    prev_req <= gpio_if.req;
    if (gpio_if.req && gpio_if.gnt) begin
      wr_q.push_back(gpio_if.wdata);
      if (gpio_if.addr != 32'h4 || gpio_if.wen !== 1'b1 || gpio_if.strb != 4'hF)
        attr_bad <= attr_bad + 1;
    end
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge g_clk); #1;
    cfg_if.req = 1'b1; cfg_if.wen = 1'b1; cfg_if.addr = a; cfg_if.wdata = d;
    @(posedge g_clk); #1;
    cfg_if.req = 1'b0; cfg_if.wen = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
    cfg_if.req = 1'b1; cfg_if.wen = 1'b0; cfg_if.addr = a;
    #1;
    d = cfg_if.rdata;
    cfg_if.req = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cfg_read(a, d);
    check(nm, d, exp);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      @(posedge g_clk); #1;
      n++;
    end
    check(nm, {31'b0, busy}, 32'h0);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    edge_q.delete();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_seq [7];
    int c0;

    cfg_if.req = 1'b0; cfg_if.wen = 1'b0; cfg_if.strb = 4'hF;
    cfg_if.addr = '0;  cfg_if.wdata = '0;
    gpio_if.gnt = 1'b1; gpio_if.error = 1'b0; gpio_if.rdata = '0;

    vecs[0]  = '{0, A_CTRL, 32'h0,     32'h0,     "rst_ctrl"};
    vecs[1]  = '{0, A_PER,  32'h0,     32'h0,     "rst_period"};
    vecs[2]  = '{0, A_STAT, 32'h0,     32'h0,     "rst_status"};
    vecs[3]  = '{1, A_PER,  32'hABCD,  32'h0,     ""};
    vecs[4]  = '{0, A_PER,  32'h0,     32'hABCD,  "period_rb"};
    vecs[5]  = '{1, A_CTRL, 32'h100,   32'h0,     ""};
    vecs[6]  = '{0, A_CTRL, 32'h0,     32'h100,   "loop_rb"};
    vecs[7]  = '{1, A_CTRL, 32'h0,     32'h0,     ""};
    vecs[8]  = '{0, A_CTRL, 32'h0,     32'h0,     "loop_clr"};
    vecs[9]  = '{1, A_DATA, 32'h5,     32'h0,     ""};
    vecs[10] = '{0, A_DATA, 32'h0,     32'h0,     "data_rd0"};
    vecs[11] = '{0, A_STAT, 32'h0,     32'h100,   "status_n1"};
    vecs[12] = '{0, 32'h1,  32'h0,     32'h0,     "unmapped"};
    vecs[13] = '{1, A_CTRL, 32'h4,     32'h0,     ""};
    vecs[14] = '{0, A_STAT, 32'h0,     32'h0,     "clear_n0"};
    vecs[15] = '{1, A_PER,  32'h2,     32'h0,     ""};
    vecs[16] = '{0, 32'h14, 32'h0,     32'h2,     "alias_period"};

    repeat (3) @(posedge g_clk);
    #1;
    check("rst_req", {31'b0, gpio_if.req}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    g_reset = 1'b0;

    // Register table
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) cfg_write(vecs[i].addr, vecs[i].data);
      else            read_check(vecs[i].nm, vecs[i].addr, vecs[i].exp);
    end

    // One-shot run of 1,2,4 with PERIOD=2
    cfg_write(A_DATA, 32'h1); cfg_write(A_DATA, 32'h2); cfg_write(A_DATA, 32'h4);
    clear_mon();
    cfg_write(A_CTRL, 32'h1);
    c0 = cyc;
    check("t1_req_next", {31'b0, gpio_if.req}, 32'h1);
    check("t1_busy", {31'b0, busy}, 32'h1);
    wait_idle("t1_done");
    repeat (3) @(posedge g_clk);
    #1;
    check("t1_nwr", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      check("t1_w0", wr_q[0], 32'h1);
      check("t1_w1", wr_q[1], 32'h2);
      check("t1_w2", wr_q[2], 32'h4);
    end
    check("t1_nedge", edge_q.size(), 3);
    if (edge_q.size() == 3) begin
      check("t1_edge0", edge_q[0], c0);
      check("t1_gap01", edge_q[1] - edge_q[0], 3);
      check("t1_gap12", edge_q[2] - edge_q[1], 3);
    end
    read_check("t1_status", A_STAT, 32'h300);

    // Looping run stopped after 7 grants
    clear_mon();
    exp_seq = '{32'h1, 32'h2, 32'h4, 32'h1, 32'h2, 32'h4, 32'h1};
    cfg_write(A_CTRL, 32'h101);
    for (int n = 0; n < 200 && wr_q.size() < 7; n++) begin
      @(negedge g_clk); #1;
    end
    cfg_write(A_CTRL, 32'h2);
    repeat (10) @(posedge g_clk);
    #1;
    check("t2_nwr", wr_q.size(), 7);
    for (int i = 0; i < 7 && i < wr_q.size(); i++) check("t2_seq", wr_q[i], exp_seq[i]);
    check("t2_busy", {31'b0, busy}, 32'h0);
    read_check("t2_status", A_STAT, 32'h300);

    // Grant stall for 5 cycles, STOP during ISSUE
    clear_mon();
    gpio_if.gnt = 1'b0;
    cfg_write(A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("t3_req_hold", {31'b0, gpio_if.req}, 32'h1);
      check("t3_wdata_hold", gpio_if.wdata, 32'h1);
      @(posedge g_clk); #1;
    end
    cfg_write(A_CTRL, 32'h2);
    check("t3_req_kept", {31'b0, gpio_if.req}, 32'h1);
    gpio_if.gnt = 1'b1;
    @(posedge g_clk); #1;
    check("t3_req_done", {31'b0, gpio_if.req}, 32'h0);
    check("t3_busy_done", {31'b0, busy}, 32'h0);
    check("t3_nwr", wr_q.size(), 1);

    // Overflow, push while busy, PUSH_ERR clear
    cfg_write(A_CTRL, 32'h4);
    for (int i = 0; i < 17; i++) cfg_write(A_DATA, 32'h10 + i);
    read_check("t4_overflow", A_STAT, 32'h1002);
    cfg_write(A_STAT, 32'h2);
    read_check("t4_perr_clr", A_STAT, 32'h1000);
    cfg_write(A_PER, 32'd10);
    cfg_write(A_CTRL, 32'h101);
    cfg_write(A_DATA, 32'h77);
    read_check("t4_busy_push", A_STAT, 32'h11003);
    cfg_write(A_CTRL, 32'h2);
    wait_idle("t4_stop");
    cfg_write(A_STAT, 32'h2);
    read_check("t4_final", A_STAT, 32'h1000);

    // START with empty buffer, START+STOP together
    cfg_write(A_CTRL, 32'h4);
    cfg_write(A_CTRL, 32'h1);
    @(posedge g_clk); #1;
    check("t5_empty_req", {31'b0, gpio_if.req}, 32'h0);
    check("t5_empty_busy", {31'b0, busy}, 32'h0);
    cfg_write(A_DATA, 32'hA); cfg_write(A_DATA, 32'hB);
    cfg_write(A_CTRL, 32'h3);
    @(posedge g_clk); #1;
    check("t5_stopwins_req", {31'b0, gpio_if.req}, 32'h0);
    check("t5_stopwins_busy", {31'b0, busy}, 32'h0);

    // Reset during WAIT
    cfg_write(A_PER, 32'd5);
    cfg_write(A_CTRL, 32'h101);
    repeat (3) @(posedge g_clk);
    #1;
    check("t6_in_wait", {30'b0, busy, gpio_if.req}, 32'h2);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    check("t6w_req", {31'b0, gpio_if.req}, 32'h0);
    check("t6w_busy", {31'b0, busy}, 32'h0);
    read_check("t6w_status", A_STAT, 32'h0);
    g_reset = 1'b0;

    // Reset during ISSUE
    cfg_write(A_DATA, 32'h3);
    gpio_if.gnt = 1'b0;
    cfg_write(A_CTRL, 32'h1);
    check("t6_in_issue", {31'b0, gpio_if.req}, 32'h1);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    check("t6i_req", {31'b0, gpio_if.req}, 32'h0);
    check("t6i_busy", {31'b0, busy}, 32'h0);
    read_check("t6i_status", A_STAT, 32'h0);
    g_reset = 1'b0;
    gpio_if.gnt = 1'b1;

    // Bus error on grant: flag set, sequence continues
    cfg_write(A_DATA, 32'h8); cfg_write(A_DATA, 32'h9);
    clear_mon();
    gpio_if.error = 1'b1;
    cfg_write(A_CTRL, 32'h1);
    wait_idle("t7_done");
    gpio_if.error = 1'b0;
    check("t7_nwr", wr_q.size(), 2);
    if (wr_q.size() == 2) check("t7_w1", wr_q[1], 32'h9);
    read_check("t7_buserr", A_STAT, 32'h204);
    cfg_write(A_STAT, 32'h4);
    read_check("t7_buserr_clr", A_STAT, 32'h200);

    check("gpio_attr", attr_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_seq.md
Name: gpio_seq

Overview:
Memory-mapped pattern sequencer that drives the GPIO peripheral's OUTPUTS register at 0x4 without CPU involvement. Software loads up to DEPTH pattern words into a local buffer, sets a step period and starts it. The block then issues one CCX write per step to the GPIO OUTPUTS register, one-shot or looping. It sits on the peripheral bus as a CCX responder (config) and in front of the GPIO peripheral as a CCX requester.

Parameters:
DEPTH, 16, pattern buffer entries (power of 2, 2..128)
PERIOD_W, 16, width of step period counter
GPIO_OUT_ADDR, 32'h0000_0004, bus address of GPIO OUTPUTS register
PERIPH_GPIO_NUM, 16, pattern word width; upper 32-PERIPH_GPIO_NUM wdata bits driven 0

Ports:
g_clk  input  1  clock
g_reset  input  1  synchronous active-high reset
cfg_if  input  scarv_ccx_memif.RSP  config/register port
gpio_if  output  scarv_ccx_memif.REQ  write port toward GPIO peripheral
busy  output  1  sequencer not IDLE

Behaviour:
- Config port: gnt tied 1, error tied 0. rdata is combinational in the request cycle, 0 for unmapped offsets. Decode uses addr[3:0].
- 0x0 CTRL. Write: bit0 START, bit1 STOP, bit2 CLEAR are pulses; bit8 LOOP is stored. Read: {23'b0, LOOP, 8'b0}.
- 0x4 PERIOD[PERIOD_W-1:0], read/write, reset 0.
- 0x8 DATA. Write while IDLE and N<DEPTH stores buf[N] and increments N. Otherwise the write is dropped and PUSH_ERR is set. Read returns 0.
- 0xC STATUS. bit0 busy, bit1 PUSH_ERR (sticky), bit2 BUS_ERR (sticky), [15:8] N, [23:16] idx. Writing 1 to bit1 or bit2 clears that bit.
- On reset: FSM=IDLE, N=0, idx=0, LOOP=0, PERIOD=0, sticky flags 0, gpio_if.req=0, busy=0. Buffer contents are don't-care.
- gpio_if drive: wen=1, strb=4'hF, addr=GPIO_OUT_ADDR, wdata={pad0, buf[idx]}. All fields are registered and held stable while req=1 until gnt.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: START with N>0 -> idx=0, ISSUE next cycle, so req is high at cycle t+1 after the START write at t. START with N=0 is ignored.
- ISSUE: req=1. On gnt, if gpio_if.error set BUS_ERR (the sequence continues). Then load counter=PERIOD and advance idx:
  - idx<N-1: idx++, go to WAIT (or straight to ISSUE if PERIOD=0).
  - idx=N-1 and LOOP=1: idx=0, same transition as above.
  - idx=N-1 and LOOP=0: go to IDLE.
- WAIT: counter decrements each cycle; at 0 go to ISSUE. Consecutive req rising edges are therefore PERIOD+1+grant_latency cycles apart.
- STOP in WAIT: IDLE next cycle.
- STOP in ISSUE: req stays high until gnt, then IDLE. A request is never withdrawn.
- START and STOP in the same write: STOP wins. START while busy is ignored.
- CLEAR while IDLE sets N=0 and idx=0. CLEAR while busy is ignored.
- LOOP and PERIOD writes while busy take effect at the next step decision or counter load.
- A synchronous reset mid-transaction drops req in the next cycle.
- busy = (FSM != IDLE), registered.

Decomposition:
- Package gpio_seq_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - register offset constants 0x0, 0x4, 0x8, 0xC;
  - CTRL and STATUS bit position constants.
- One sub-module, gpio_seq_buf: DEPTH x PERIPH_GPIO_NUM register-file buffer with write index N and combinational read at idx, plus count/full logic.
- The FSM, timer and register decode stay in gpio_seq.

Test Plan:
- Load 3 words (0x1, 0x2, 0x4), PERIOD=2, LOOP=0, START; GPIO gnt always 1 -> exactly 3 writes to 0x4, with req rising edges 3 cycles apart. Then IDLE, busy=0, STATUS.idx=0.
- Same buffer, LOOP=1, START, then STOP after 7 grants -> write sequence 1,2,4,1,2,4,1, no further writes, and STATUS N still 3.
- Hold gpio_if.gnt low for 5 cycles during ISSUE, then issue STOP -> req and wdata are stable for all 5 cycles, the write completes on gnt, then IDLE.
- Push 17 words with DEPTH=16 -> N=16, PUSH_ERR=1. Push during busy -> N unchanged, PUSH_ERR=1. Write 0x2 to STATUS -> PUSH_ERR=0.
- START with N=0 -> no req, busy=0. Write CTRL=0x3 while IDLE with N=2 -> no req (STOP wins).
- Assert g_reset during WAIT and during ISSUE -> next cycle req=0, busy=0, N=0, STATUS reads 0. Drive error=1 on a grant -> BUS_ERR=1 and the sequence continues.
